// File: rtl/fb_swap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_swap_ctrl_pkg
//  Description : Shared types for the framebuffer double-buffer controller.
//                Holds the screen coordinate struct, the RAM address layout
//                {bank, y, x} and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_swap_ctrl_pkg;

    localparam int FB_ADDR_W = 18;

    // Screen coordinate pair: x spans 0..511, y spans 0..255.
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } screenXY;

    // RAM address: nested fields, not a linear pixel index.
    typedef struct packed {
        logic       bank;
        logic [7:0] y;
        logic [8:0] x;
    } fb_addr_t;

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        RENDER     = 2'd1,
        WAIT_VSYNC = 2'd2,
        CLEAR      = 2'd3
    } fb_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_clear_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : fb_clear_sweep
//  Description : Nested x/y(/bank) address counter for framebuffer clears.
//                x is the inner loop, then y, then (optionally) bank.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                start          - zero all counters (priority over advance)
//                advance        - step to the next address
//                two_banks      - 1: sweep bank 0 then 1; 0: single bank
//                base_bank      - bank used when two_banks = 0
//                addr           - current sweep address
//                last           - current address is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_clear_sweep
    import fb_swap_ctrl_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     start,
    input  logic     advance,
    input  logic     two_banks,
    input  logic     base_bank,
    output fb_addr_t addr,
    output logic     last
);

    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    logic [8:0] cx_q, cx_d;
    logic [7:0] cy_q, cy_d;
    logic       cb_q, cb_d;
    logic       x_end, y_end, b_end;

    always_comb begin
        x_end     = (cx_q == X_LAST);
        y_end     = (cy_q == Y_LAST);
        b_end     = ~two_banks | cb_q;
        last      = x_end & y_end & b_end;

        addr.bank = two_banks ? cb_q : base_bank;
        addr.y    = cy_q;
        addr.x    = cx_q;

        cx_d = cx_q;
        cy_d = cy_q;
        cb_d = cb_q;
        if (start || (advance && last)) begin
            // Wrapping to zero after the final address leaves the counters
            // ready for the next sweep even without an explicit start.
            cx_d = '0;
            cy_d = '0;
            cb_d = 1'b0;
        end else if (advance) begin
            if (x_end) begin
                cx_d = '0;
                if (y_end) begin
                    cy_d = '0;
                    cb_d = ~cb_q;
                end else begin
                    cy_d = cy_q + 8'd1;
                end
            end else begin
                cx_d = cx_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
            cb_q <= 1'b0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            cb_q <= cb_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_swap_ctrl
//  Description : Double-buffer controller for a 3-bit palette framebuffer.
//                Display reads the front bank; the renderer writes the back
//                bank. After render_done the banks swap on the next vsync
//                rising edge, then the new back bank is cleared before
//                renderer writes reopen.
//  Ports       : Clk, Reset_n          - clock, async active-low reset
//                new_frame             - vsync level
//                disp_coords/mem_raddr - display read address (combinational)
//                wr_req/wr_ready       - renderer write handshake
//                wr_coords/wr_color    - renderer write position and colour
//                render_done           - back bank complete (pulse)
//                mem_we/waddr/wdata    - registered RAM write port
//                front_sel             - bank being displayed
//                frame_start           - pulse on entry to RENDER
//                held_frames           - saturating count of unswapped vsyncs
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_swap_ctrl
    import fb_swap_ctrl_pkg::*;
#(
    parameter int         WIDTH       = 320,
    parameter int         HEIGHT      = 240,
    parameter logic [2:0] CLEAR_COLOR = 3'd0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 new_frame,
    input  screenXY              disp_coords,
    output logic [FB_ADDR_W-1:0] mem_raddr,
    input  logic                 wr_req,
    output logic                 wr_ready,
    input  screenXY              wr_coords,
    input  logic [2:0]           wr_color,
    input  logic                 render_done,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_waddr,
    output logic [2:0]           mem_wdata,
    output logic                 front_sel,
    output logic                 frame_start,
    output logic [7:0]           held_frames
);

    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    fb_state_e  state_q, state_d;
    logic       front_sel_q, front_sel_d;
    logic [7:0] held_q, held_d;
    logic       mem_we_q, mem_we_d;
    fb_addr_t   mem_waddr_q, mem_waddr_d;
    logic [2:0] mem_wdata_q, mem_wdata_d;
    logic       frame_start_q, frame_start_d;
    logic       new_frame_q, new_frame_d;

    logic       vs_edge;
    logic       held_inc;
    logic       sweep_start, sweep_adv, sweep_two;
    fb_addr_t   sweep_addr;
    logic       sweep_last;

    fb_clear_sweep #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_sweep (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .start     (sweep_start),
        .advance   (sweep_adv),
        .two_banks (sweep_two),
        .base_bank (~front_sel_q),
        .addr      (sweep_addr),
        .last      (sweep_last)
    );

    always_comb begin
        vs_edge       = new_frame & ~new_frame_q;
        new_frame_d   = new_frame;

        state_d       = state_q;
        front_sel_d   = front_sel_q;
        mem_we_d      = 1'b0;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        frame_start_d = 1'b0;
        wr_ready      = 1'b0;
        held_inc      = 1'b0;
        sweep_start   = 1'b0;
        sweep_adv     = 1'b0;
        sweep_two     = (state_q == INIT);

        case (state_q)
            INIT, CLEAR: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = sweep_addr;
                mem_wdata_d = CLEAR_COLOR;
                sweep_adv   = 1'b1;
                held_inc    = (state_q == CLEAR) & vs_edge;
                if (sweep_last) begin
                    state_d       = RENDER;
                    frame_start_d = 1'b1;
                end
            end
            RENDER: begin
                wr_ready = 1'b1;
                held_inc = vs_edge;
                // Off-screen writes complete the handshake but never reach RAM.
                if (wr_req && (wr_coords.x <= X_LAST) && (wr_coords.y <= Y_LAST)) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = {~front_sel_q, wr_coords.y, wr_coords.x};
                    mem_wdata_d = wr_color;
                end
                if (render_done) begin
                    state_d = WAIT_VSYNC;
                end
            end
            WAIT_VSYNC: begin
                if (vs_edge) begin
                    front_sel_d = ~front_sel_q;
                    sweep_start = 1'b1;
                    state_d     = CLEAR;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        held_d = held_q;
        if (held_inc && (held_q != 8'hFF)) begin
            held_d = held_q + 8'd1;
        end
    end

    // The edge register resets high so vsync already active at reset
    // release is not mistaken for a rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= INIT;
            front_sel_q   <= 1'b0;
            held_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= '0;
            frame_start_q <= 1'b0;
            new_frame_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            front_sel_q   <= front_sel_d;
            held_q        <= held_d;
            mem_we_q      <= mem_we_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wdata_q   <= mem_wdata_d;
            frame_start_q <= frame_start_d;
            new_frame_q   <= new_frame_d;
        end
    end

    assign mem_raddr   = {front_sel_q, disp_coords.y, disp_coords.x};
    assign mem_we      = mem_we_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign front_sel   = front_sel_q;
    assign frame_start = frame_start_q;
    assign held_frames = held_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_swap_ctrl
//  Description : Self-checking bench for fb_swap_ctrl. The DUT is built with
//                a reduced 40x12 frame so full sweeps stay short; all
//                expectations are derived from W and H below.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_swap_ctrl;
    import fb_swap_ctrl_pkg::*;

    localparam int W      = 40;
    localparam int H      = 12;
    localparam int N_INIT = 2 * W * H;
    localparam int N_CLR  = W * H;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        new_frame;
    screenXY     disp_coords;
    logic [17:0] mem_raddr;
    logic        wr_req;
    logic        wr_ready;
    screenXY     wr_coords;
    logic [2:0]  wr_color;
    logic        render_done;
    logic        mem_we;
    logic [17:0] mem_waddr;
    logic [2:0]  mem_wdata;
    logic        front_sel;
    logic        frame_start;
    logic [7:0]  held_frames;

    fb_swap_ctrl #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .CLEAR_COLOR (3'd0)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .new_frame   (new_frame),
        .disp_coords (disp_coords),
        .mem_raddr   (mem_raddr),
        .wr_req      (wr_req),
        .wr_ready    (wr_ready),
        .wr_coords   (wr_coords),
        .wr_color    (wr_color),
        .render_done (render_done),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .front_sel   (front_sel),
        .frame_start (frame_start),
        .held_frames (held_frames)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic b, input int y, input int x);
        return {b, y[7:0], x[8:0]};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic vsync_pulse();
        new_frame = 1'b1;
        tick();
        tick();
        new_frame = 1'b0;
        tick();
        tick();
    endtask

    // Walks a full clear sweep, comparing every issued write against the
    // nested x/y/bank order; wr_ready and frame_start rise only as the final
    // write appears (that cycle is the first one in RENDER).
    task automatic run_sweep(input string tag, input int n, input bit two, input logic bank);
        int   bad_we;
        int   bad_addr;
        int   bad_rdy;
        int   bad_fs;
        logic b;
        bad_we   = 0;
        bad_addr = 0;
        bad_rdy  = 0;
        bad_fs   = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            b = two ? (k >= W * H) : bank;
            if (mem_we !== 1'b1 || mem_wdata !== 3'd0) bad_we++;
            if (mem_waddr !== mk(b, (k / W) % H, k % W)) bad_addr++;
            if (wr_ready !== (k == n - 1)) bad_rdy++;
            if (frame_start !== (k == n - 1)) bad_fs++;
        end
        check({tag, "_we_wdata_errs"}, bad_we, 0);
        check({tag, "_addr_errs"}, bad_addr, 0);
        check({tag, "_wr_ready_errs"}, bad_rdy, 0);
        check({tag, "_frame_start_errs"}, bad_fs, 0);
    endtask

    typedef struct {
        logic        req;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic        exp_we;
        logic [17:0] exp_addr;
        logic [2:0]  exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bad;

        vecs[0] = '{1'b1, 9'd5,        8'd7,        3'd3, 1'b1, mk(1'b1, 7, 5),         3'd3};
        vecs[1] = '{1'b1, 9'(W),       8'd0,        3'd4, 1'b0, 18'd0,                  3'd0};
        vecs[2] = '{1'b1, 9'd0,        8'(H),       3'd2, 1'b0, 18'd0,                  3'd0};
        vecs[3] = '{1'b1, 9'(W - 1),   8'(H - 1),   3'd7, 1'b1, mk(1'b1, H - 1, W - 1), 3'd7};
        vecs[4] = '{1'b0, 9'd1,        8'd1,        3'd1, 1'b0, 18'd0,                  3'd0};
        vecs[5] = '{1'b1, 9'd0,        8'd0,        3'd5, 1'b1, mk(1'b1, 0, 0),         3'd5};

        Reset_n       = 1'b0;
        new_frame     = 1'b0;
        wr_req        = 1'b0;
        wr_coords     = '0;
        wr_color      = 3'd0;
        render_done   = 1'b0;
        disp_coords.x = 9'd10;
        disp_coords.y = 8'd3;
        repeat (3) tick();

        // Reset state
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_front_sel", front_sel, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_held", held_frames, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_raddr", mem_raddr, mk(1'b0, 3, 10));

        // INIT sweep of both banks
        Reset_n = 1'b1;
        run_sweep("init", N_INIT, 1'b1, 1'b0);
        tick();
        check("post_init_we", mem_we, 0);
        check("post_init_fs", frame_start, 0);
        check("post_init_ready", wr_ready, 1);

        // Renderer writes, table driven
        for (int i = 0; i < 6; i++) begin
            wr_req      = vecs[i].req;
            wr_coords.x = vecs[i].x;
            wr_coords.y = vecs[i].y;
            wr_color    = vecs[i].c;
            tick();
            check($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
            check($sformatf("vec%0d_ready", i), wr_ready, 1);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_waddr", i), mem_waddr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_data);
            end
        end
        wr_req = 1'b0;
        tick();

        // Three vsync edges while rendering
        repeat (3) vsync_pulse();
        check("held_3", held_frames, 3);

        // Swap: render_done, then a vsync edge 1000 cycles later
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        check("swap_ready_drop", wr_ready, 0);
        wr_req      = 1'b1;
        wr_coords.x = 9'd1;
        wr_coords.y = 8'd1;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            render_done = (k == 500);
            tick();
            if (mem_we !== 1'b0 || wr_ready !== 1'b0 || front_sel !== 1'b0) bad++;
        end
        render_done = 1'b0;
        wr_req      = 1'b0;
        check("wait_vsync_idle_errs", bad, 0);
        new_frame = 1'b1;
        tick();
        check("swap_front_sel", front_sel, 1);
        check("swap_held_unchanged", held_frames, 3);
        check("swap_raddr", mem_raddr, mk(1'b1, 3, 10));
        run_sweep("clear", N_CLR, 1'b0, 1'b0);
        tick();
        check("post_clear_we", mem_we, 0);
        check("post_clear_fs", frame_start, 0);
        check("post_clear_ready", wr_ready, 1);

        // Saturation: 297 more edges, 300 in total
        new_frame = 1'b0;
        tick();
        repeat (297) vsync_pulse();
        check("held_sat", held_frames, 255);

        // render_done and a write in the same cycle
        wr_req      = 1'b1;
        wr_coords.x = 9'd2;
        wr_coords.y = 8'd4;
        wr_color    = 3'd6;
        render_done = 1'b1;
        tick();
        wr_req      = 1'b0;
        render_done = 1'b0;
        check("simul_we", mem_we, 1);
        check("simul_waddr", mem_waddr, mk(1'b0, 4, 2));
        check("simul_wdata", mem_wdata, 6);
        check("simul_ready", wr_ready, 0);

        // Second swap back to bank 0, clearing bank 1
        new_frame = 1'b1;
        tick();
        check("swap2_front_sel", front_sel, 0);
        run_sweep("clear2", N_CLR, 1'b0, 1'b1);

        // Third swap, then reset partway through the clear with vsync high
        new_frame = 1'b0;
        tick();
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        tick();
        new_frame = 1'b1;
        tick();
        check("swap3_front_sel", front_sel, 1);
        repeat (200) tick();
        check("mid_clear_we", mem_we, 1);
        Reset_n = 1'b0;
        #1;
        check("async_rst_we", mem_we, 0);
        check("async_rst_waddr", mem_waddr, 0);
        check("async_rst_wdata", mem_wdata, 0);
        check("async_rst_front", front_sel, 0);
        check("async_rst_held", held_frames, 0);
        check("async_rst_fs", frame_start, 0);
        check("async_rst_ready", wr_ready, 0);
        repeat (3) tick();
        check("held_rst_we", mem_we, 0);
        Reset_n = 1'b1;
        run_sweep("init2", N_INIT, 1'b1, 1'b0);
        repeat (5) tick();
        check("no_false_edge_held", held_frames, 0);
        check("init2_front", front_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run length so a stuck design still reaches a verdict.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
